// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder for the initialization command set.
// Decodes 48-bit command frames from the host and answers with R1/R3/R7
// responses on miso. Used as a card model for loopback bring-up.
module sd_spi_responder #(
  parameter int NCR         = 1,
  parameter int INIT_POLLS  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_ok,
  output logic        in_idle
);

  typedef enum logic [1:0] {HUNT, RX_CMD, WAIT_NCR, TX_RESP} state_t;

  localparam logic [7:0] POLL_MAX = 8'(INIT_POLLS);
  localparam logic [3:0] NCR_W    = 4'(NCR);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s, sclk_prev, sclk_rise, sclk_fall;

  logic [7:0]      rx_shift, tx_shift;
  logic [2:0]      bit_cnt, byte_cnt;
  logic            byte_done;
  state_t          state;
  logic [5:0]      idx_r;
  logic [31:0]     arg_r;
  logic [6:0]      crc_r;
  logic [3:0]      ncr_cnt;
  logic [4:0][7:0] resp_buf;
  logic [2:0]      resp_len, resp_idx;
  logic [7:0]      polls;
  logic            app, hcs;

  // next-state of the card after executing the frame currently completing
  logic            frame_crc_good, crc_err, illegal;
  logic            x_idle, x_app, x_hcs;
  logic [7:0]      x_polls, r1;
  logic [4:0][7:0] x_resp;
  logic [2:0]      x_len;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // Serial CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic [7:0] d;
    logic       fb;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = d[7] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  // Resynchronize the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
    end else begin
      sclk_sync[0] <= spi_clk;
      cs_sync[0]   <= cs;
      mosi_sync[0] <= mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
    end
  end

  // Command execution: card state update and response bytes for the frame
  always_comb begin
    frame_crc_good = (rx_shift[7:1] == crc_r) && rx_shift[0];
    x_idle  = in_idle;
    x_polls = polls;
    x_hcs   = hcs;
    x_app   = (idx_r == 6'd55) && frame_crc_good;
    x_resp  = '1;
    x_len   = 3'd1;
    crc_err = 1'b0;
    illegal = 1'b0;
    if ((idx_r == 6'd0 || idx_r == 6'd8) && !frame_crc_good) begin
      crc_err = 1'b1;
    end else begin
      case (idx_r)
        6'd0: begin
          x_idle  = 1'b1;
          x_polls = '0;
          x_hcs   = 1'b0;
        end
        6'd8, 6'd55, 6'd58: ;
        6'd41: begin
          if (app) begin
            x_hcs = arg_r[30];
            if (polls < POLL_MAX) x_polls = polls + 8'd1;
            if (x_polls == POLL_MAX) x_idle = 1'b0;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
    r1 = {4'b0, crc_err, illegal, 1'b0, x_idle};
    x_resp[0] = r1;
    if (!crc_err && idx_r == 6'd8) begin
      x_resp[1] = 8'h00;
      x_resp[2] = 8'h00;
      x_resp[3] = {4'h0, arg_r[11:8]};
      x_resp[4] = arg_r[7:0];
      x_len     = 3'd5;
    end else if (!crc_err && idx_r == 6'd58) begin
      x_resp[1] = {~x_idle, x_hcs, 6'b0};
      x_resp[2] = 8'hFF;
      x_resp[3] = 8'h80;
      x_resp[4] = 8'h00;
      x_len     = 3'd5;
    end
  end

  // Bit engine plus frame/response FSM; byte_done lags the last rising edge by one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '1;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_done <= 1'b0;
      state     <= HUNT;
      idx_r     <= '0;
      arg_r     <= '0;
      crc_r     <= '0;
      ncr_cnt   <= '0;
      resp_buf  <= '1;
      resp_len  <= 3'd1;
      resp_idx  <= '0;
      polls     <= '0;
      app       <= 1'b0;
      hcs       <= 1'b0;
      miso      <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      crc_ok    <= 1'b0;
      in_idle   <= 1'b1;
    end else begin
      sclk_prev <= sclk_s;
      cmd_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        tx_shift  <= '1;
        miso      <= 1'b1;
        state     <= HUNT;
      end else begin
        byte_done <= 1'b0;
        if (sclk_rise) begin
          rx_shift  <= {rx_shift[6:0], mosi_s};
          bit_cnt   <= bit_cnt + 3'd1;
          byte_done <= (bit_cnt == 3'd7);
        end
        if (sclk_fall) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
        if (byte_done) begin
          case (state)
            HUNT: begin
              tx_shift <= '1;
              if (rx_shift[7:6] == 2'b01) begin
                idx_r    <= rx_shift[5:0];
                crc_r    <= crc7_step(7'd0, rx_shift);
                byte_cnt <= 3'd1;
                state    <= RX_CMD;
              end
            end
            RX_CMD: begin
              if (byte_cnt != 3'd5) begin
                arg_r    <= {arg_r[23:0], rx_shift};
                crc_r    <= crc7_step(crc_r, rx_shift);
                byte_cnt <= byte_cnt + 3'd1;
                tx_shift <= '1;
              end else begin
                cmd_valid <= 1'b1;
                cmd_index <= idx_r;
                cmd_arg   <= arg_r;
                crc_ok    <= frame_crc_good;
                in_idle   <= x_idle;
                polls     <= x_polls;
                app       <= x_app;
                hcs       <= x_hcs;
                resp_buf  <= x_resp;
                resp_len  <= x_len;
                if (NCR == 0) begin
                  tx_shift <= x_resp[0];
                  resp_idx <= 3'd1;
                  state    <= TX_RESP;
                end else begin
                  tx_shift <= '1;
                  ncr_cnt  <= 4'd1;
                  state    <= WAIT_NCR;
                end
              end
            end
            WAIT_NCR: begin
              if (ncr_cnt == NCR_W) begin
                tx_shift <= resp_buf[0];
                resp_idx <= 3'd1;
                state    <= TX_RESP;
              end else begin
                ncr_cnt  <= ncr_cnt + 4'd1;
                tx_shift <= '1;
              end
            end
            TX_RESP: begin
              if (resp_idx == resp_len) begin
                tx_shift <= '1;
                state    <= HUNT;
              end else begin
                tx_shift <= resp_buf[resp_idx];
                resp_idx <= resp_idx + 3'd1;
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: drives SPI mode-0 frames as a host would and
// checks responses and decoded-frame outputs against a card-level model.
module tb_sd_spi_responder;

  localparam int NCR        = 1;
  localparam int INIT_POLLS = 2;
  localparam int HALF       = 80;

  logic        clk = 1'b0;
  logic        rst, spi_clk, cs, mosi;
  logic        miso, cmd_valid, crc_ok, in_idle;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  always #5 clk = ~clk;

  sd_spi_responder #(.NCR(NCR), .INIT_POLLS(INIT_POLLS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
    .miso(miso), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .crc_ok(crc_ok), .in_idle(in_idle)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Card model: idle flag, accepted ACMD41 count, app-command flag, HCS bit
  logic m_idle = 1'b1;
  int   m_polls = 0;
  logic m_app = 1'b0;
  logic m_hcs = 1'b0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc;
    logic        idle;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_polls = 0; m_app = 1'b0; m_hcs = 1'b0;
  endtask

  // Applies one frame to the model; rsp holds response bytes left-aligned
  task automatic model_frame(input logic [47:0] frame, output logic [39:0] rsp,
                             output int len, output logic crc_good);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        was_app, ill;
    logic [7:0]  r;
    idx      = frame[45:40];
    arg      = frame[39:8];
    crc_good = (frame[7:0] == {crc7_ref(frame[47:8]), 1'b1});
    was_app  = m_app;
    m_app    = (idx == 6'd55) && crc_good;
    rsp      = '1;
    len      = 1;
    if ((idx == 6'd0 || idx == 6'd8) && !crc_good) begin
      rsp[39:32] = 8'h08 | {7'b0, m_idle};
    end else begin
      ill = 1'b0;
      if (idx == 6'd0) begin
        m_idle = 1'b1; m_polls = 0; m_hcs = 1'b0;
      end else if (idx == 6'd41) begin
        if (was_app) begin
          m_hcs = arg[30];
          if (m_polls < INIT_POLLS) m_polls++;
          if (m_polls == INIT_POLLS) m_idle = 1'b0;
        end else ill = 1'b1;
      end else if (idx != 6'd8 && idx != 6'd55 && idx != 6'd58) begin
        ill = 1'b1;
      end
      r = (ill ? 8'h04 : 8'h00) | {7'b0, m_idle};
      if (idx == 6'd8) begin
        rsp = {r, 16'h0000, 4'h0, arg[11:8], arg[7:0]};
        len = 5;
      end else if (idx == 6'd58) begin
        rsp = {r, ~m_idle, m_hcs, 6'b0, 24'hFF8000};
        len = 5;
      end else begin
        rsp[39:32] = r;
      end
    end
  endtask

  // Every decoded frame must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      if (exp_q.size() == 0) begin
        check("cmd_valid_unexpected", {39'b0, cmd_valid}, 40'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_index", {34'b0, cmd_index}, {34'b0, mon_e.idx});
        check("cmd_arg", {8'b0, cmd_arg}, {8'b0, mon_e.arg});
        check("crc_ok", {39'b0, crc_ok}, {39'b0, mon_e.crc});
        check("in_idle_at_frame", {39'b0, in_idle}, {39'b0, mon_e.idle});
      end
    end
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #(HALF);
      rx[i] = miso;
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  // One filler byte, the 6-byte frame, NCR fill, then up to nread response bytes
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                        input int nread, output logic [39:0] got);
    logic [47:0] frame;
    logic [39:0] rsp;
    int          len, n;
    logic        cg;
    logic [7:0]  rx;
    exp_t        e;
    frame[47:8] = {2'b01, idx, arg};
    frame[7:0]  = bad_crc ? 8'h00 : {crc7_ref(frame[47:8]), 1'b1};
    model_frame(frame, rsp, len, cg);
    e.idx = idx; e.arg = arg; e.crc = cg; e.idle = m_idle;
    exp_q.push_back(e);
    xfer(8'hFF, rx);
    check("hunt_fill", {32'b0, rx}, 40'hFF);
    for (int i = 0; i < 6; i++) begin
      xfer(frame[47-8*i -: 8], rx);
      check("cmd_fill", {32'b0, rx}, 40'hFF);
    end
    for (int i = 0; i < NCR; i++) begin
      xfer(8'hFF, rx);
      check("ncr_fill", {32'b0, rx}, 40'hFF);
    end
    got = '1;
    n = (nread < len) ? nread : len;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, rx);
      got[39-8*i -: 8] = rx;
      check("resp_byte", {32'b0, rx}, {32'b0, rsp[39-8*i -: 8]});
    end
  endtask

  initial begin
    logic [39:0] got;
    logic [7:0]  rx;
    logic [6:0]  c;
    rst = 1'b1; spi_clk = 1'b0; cs = 1'b1; mosi = 1'b1;
    #2;
    #20;
    check("rst_miso", {39'b0, miso}, 40'd1);
    check("rst_cmd_valid", {39'b0, cmd_valid}, 40'd0);
    check("rst_cmd_index", {34'b0, cmd_index}, 40'd0);
    check("rst_cmd_arg", {8'b0, cmd_arg}, 40'd0);
    check("rst_crc_ok", {39'b0, crc_ok}, 40'd0);
    check("rst_in_idle", {39'b0, in_idle}, 40'd1);
    rst = 1'b0;
    #40;
    cs = 1'b0;
    #40;

    // model pins: well-known CRC bytes 0x95 and 0x87
    c = crc7_ref(40'h4000000000);
    check("crc_cmd0", {33'b0, c}, 40'h4A);
    c = crc7_ref(40'h48000001AA);
    check("crc_cmd8", {33'b0, c}, 40'h43);

    do_cmd(6'd0, 32'h0, 1'b0, 5, got);
    check("cmd0_r1", got, 40'h01FFFFFFFF);
    do_cmd(6'd8, 32'h000001AA, 1'b0, 5, got);
    check("cmd8_r7", got, 40'h01000001AA);

    do_cmd(6'd55, 32'h0, 1'b0, 5, got);
    check("cmd55_a", {32'b0, got[39:32]}, 40'h01);
    do_cmd(6'd41, 32'h40000000, 1'b0, 5, got);
    check("acmd41_a", {32'b0, got[39:32]}, 40'h01);
    check("idle_after_a", {39'b0, in_idle}, 40'd1);
    do_cmd(6'd55, 32'h0, 1'b0, 5, got);
    do_cmd(6'd41, 32'h40000000, 1'b0, 5, got);
    check("acmd41_b", {32'b0, got[39:32]}, 40'h00);
    check("idle_after_b", {39'b0, in_idle}, 40'd0);
    do_cmd(6'd58, 32'h0, 1'b0, 5, got);
    check("cmd58_r3", got, 40'h00C0FF8000);

    do_cmd(6'd0, 32'h0, 1'b0, 5, got);
    do_cmd(6'd0, 32'h0, 1'b1, 5, got);
    check("cmd0_badcrc", {32'b0, got[39:32]}, 40'h09);
    check("idle_after_badcrc", {39'b0, in_idle}, 40'd1);
    do_cmd(6'd41, 32'h40000000, 1'b0, 5, got);
    check("cmd41_noapp", {32'b0, got[39:32]}, 40'h05);
    do_cmd(6'd17, 32'h0, 1'b0, 5, got);
    check("cmd17_illegal", {32'b0, got[39:32]}, 40'h05);

    // partial frame dropped by cs
    xfer(8'h40, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    cs = 1'b1;
    #200;
    cs = 1'b0;
    #80;
    do_cmd(6'd0, 32'h0, 1'b0, 5, got);
    check("cmd0_after_abort", {32'b0, got[39:32]}, 40'h01);

    // response cut short by cs
    do_cmd(6'd8, 32'h000001AA, 1'b0, 2, got);
    cs = 1'b1;
    #200;
    cs = 1'b0;
    #80;
    do_cmd(6'd0, 32'h0, 1'b0, 5, got);
    check("cmd0_after_cut", {32'b0, got[39:32]}, 40'h01);

    // reset in the middle of a CMD58 response
    do_cmd(6'd55, 32'h0, 1'b0, 5, got);
    do_cmd(6'd41, 32'h40000000, 1'b0, 5, got);
    do_cmd(6'd55, 32'h0, 1'b0, 5, got);
    do_cmd(6'd41, 32'h40000000, 1'b0, 5, got);
    do_cmd(6'd58, 32'h0, 1'b0, 0, got);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      #(HALF);
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
    #(HALF);
    check("miso_before_rst", {39'b0, miso}, 40'd0);
    check("idle_before_rst", {39'b0, in_idle}, 40'd0);
    rst = 1'b1;
    #1;
    check("midrsp_rst_miso", {39'b0, miso}, 40'd1);
    check("midrsp_rst_idle", {39'b0, in_idle}, 40'd1);
    check("midrsp_rst_index", {34'b0, cmd_index}, 40'd0);
    model_reset();
    #9;
    #30;
    rst = 1'b0;
    #100;
    do_cmd(6'd0, 32'h0, 1'b0, 5, got);
    check("cmd0_after_rst", {32'b0, got[39:32]}, 40'h01);

    #200;
    check("frames_all_seen", {8'b0, 32'(exp_q.size())}, 40'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
